// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns per-stage stall requests into the stall bus and runs the
// exception/ERET redirect sequence. It also provides a stall watchdog and a stall-cycle counter.
module pipe_ctrl #(
    parameter int          TIMEOUT       = 1024,
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter int          REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [3:0]  RC_INIT = (REFILL_CYCLES > 0) ? 4'(REFILL_CYCLES - 1) : 4'd0;
    localparam logic [15:0] WD_MAX  = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_refill_cnt;
    logic [15:0] r_wd_cnt;
    logic [31:0] r_new_pc;
    logic        r_timeout;
    logic [31:0] r_stall_cnt;
    logic        w_accept;
    logic        w_stalled;

    // A MEM-stage stall holds the exception/ERET in MEM, so it is not taken that cycle.
    assign w_accept  = (r_state == IDLE) && (exc_i || eret_i) && !stallreq_mem;
    assign w_stalled = (stall_o != 6'b000000);

    always_comb begin
        stall_o = 6'b000000;
        if (r_state != FLUSH) begin
            if (stallreq_mem)      stall_o = 6'b011111;
            else if (stallreq_ex)  stall_o = 6'b001111;
            else if (stallreq_id)  stall_o = 6'b000111;
            else if (stallreq_if)  stall_o = 6'b000011;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = FLUSH;
            FLUSH:   w_next = (REFILL_CYCLES > 0) ? REFILL : IDLE;
            REFILL:  if (r_refill_cnt == 4'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_new_pc     <= 32'h0;
            r_refill_cnt <= 4'd0;
            r_wd_cnt     <= 16'd0;
            r_timeout    <= 1'b0;
            r_stall_cnt  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_new_pc <= exc_i ? EXC_VECTOR : epc_i;
            if (r_state == FLUSH)
                r_refill_cnt <= RC_INIT;
            else if ((r_state == REFILL) && (r_refill_cnt != 4'd0))
                r_refill_cnt <= r_refill_cnt - 4'd1;
            if (w_stalled) begin
                if (r_wd_cnt != WD_MAX)
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                if (r_wd_cnt >= WD_MAX - 16'd1)
                    r_timeout <= 1'b1;
                if (r_stall_cnt != 32'hFFFFFFFF)
                    r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_wd_cnt <= 16'd0;
            end
        end
    end

    assign flush_o     = (r_state == FLUSH);
    assign busy_o      = (r_state != IDLE);
    assign new_pc_o    = r_new_pc;
    assign timeout_o   = r_timeout;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one DUT with TIMEOUT=4/REFILL_CYCLES=2 and one with
// REFILL_CYCLES=0 sharing the same stimulus.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        exc_i = 1'b0, eret_i = 1'b0;
    logic [31:0] epc_i = 32'h0;

    logic [5:0]  stall_o, stall0_o;
    logic        flush_o, flush0_o, busy_o, busy0_o, timeout_o, timeout0_o;
    logic [31:0] new_pc_o, new_pc0_o, stall_cnt_o, stall_cnt0_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(4), .EXC_VECTOR(32'h00000020), .REFILL_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_i(exc_i), .eret_i(eret_i), .epc_i(epc_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    pipe_ctrl #(.TIMEOUT(1024), .EXC_VECTOR(32'h00000020), .REFILL_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_i(exc_i), .eret_i(eret_i), .epc_i(epc_i),
        .stall_o(stall0_o), .flush_o(flush0_o), .new_pc_o(new_pc0_o),
        .busy_o(busy0_o), .timeout_o(timeout0_o), .stall_cnt_o(stall_cnt0_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_i = 0; eret_i = 0; epc_i = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({flush_o, busy_o, timeout_o} !== 3'b000 || stall_o !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: flush=%b busy=%b timeout=%b stall=%b, want 0 0 0 000000",
                     flush_o, busy_o, timeout_o, stall_o);
        end
        tests_run++;
        if (new_pc_o !== 32'h0 || stall_cnt_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: new_pc=%h stall_cnt=%0d, want 0 0", new_pc_o, stall_cnt_o);
        end
    endtask

    task automatic test_priority();
        logic [3:0] req [6]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0101};
        logic [5:0] want [6] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b011111, 6'b001111};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req[i];
            #1;
            tests_run++;
            if (stall_o !== want[i]) begin
                tests_failed++;
                $display("FAIL priority[%0d]: stall=%b, want %b", i, stall_o, want[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_ex_stall();
        do_reset();
        stallreq_ex = 1;
        stallreq_if = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (stall_o !== 6'b001111) begin
                tests_failed++;
                $display("FAIL ex_stall[%0d]: stall=%b, want 001111", i, stall_o);
            end
            step();
        end
        clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt_o !== 32'd3 || timeout_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ex_stall_cnt: stall_cnt=%0d timeout=%b, want 3 0", stall_cnt_o, timeout_o);
        end
    endtask

    task automatic test_exc_flush();
        int busy_n = 0;
        int flush_n = 0;
        do_reset();
        exc_i = 1; eret_i = 1; epc_i = 32'h00001000;
        step();
        clear_inputs();
        tests_run++;
        if (flush_o !== 1'b1 || new_pc_o !== 32'h00000020 || stall_o !== 6'b0) begin
            tests_failed++;
            $display("FAIL exc_flush: flush=%b new_pc=%h stall=%b, want 1 00000020 000000",
                     flush_o, new_pc_o, stall_o);
        end
        for (int i = 0; i < 8; i++) begin
            if (busy_o) busy_n++;
            if (flush_o) flush_n++;
            step();
        end
        tests_run++;
        if (busy_n != 3 || flush_n != 1) begin
            tests_failed++;
            $display("FAIL exc_busy_len: busy cycles=%0d flush cycles=%0d, want 3 1", busy_n, flush_n);
        end
        tests_run++;
        if (new_pc_o !== 32'h00000020) begin
            tests_failed++;
            $display("FAIL exc_pc_hold: new_pc=%h, want 00000020", new_pc_o);
        end
    endtask

    task automatic test_eret_mem_stall();
        do_reset();
        eret_i = 1; epc_i = 32'h00400100; stallreq_mem = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (stall_o !== 6'b011111) begin
                tests_failed++;
                $display("FAIL eret_stall[%0d]: stall=%b, want 011111", i, stall_o);
            end
            step();
            tests_run++;
            if (flush_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL eret_held[%0d]: flush=%b, want 0", i, flush_o);
            end
        end
        stallreq_mem = 0;
        step();
        clear_inputs();
        tests_run++;
        if (flush_o !== 1'b1 || new_pc_o !== 32'h00400100) begin
            tests_failed++;
            $display("FAIL eret_release: flush=%b new_pc=%h, want 1 00400100", flush_o, new_pc_o);
        end
    endtask

    task automatic test_exc_in_refill();
        do_reset();
        exc_i = 1;
        step();
        exc_i = 0;
        step();
        exc_i = 1;
        epc_i = 32'hDEAD0000;
        step();
        exc_i = 0;
        tests_run++;
        if (flush_o !== 1'b0 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL refill_ignore: flush=%b busy=%b, want 0 1", flush_o, busy_o);
        end
        step();
        tests_run++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill_done: flush=%b busy=%b, want 0 0", flush_o, busy_o);
        end
        step();
        tests_run++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill_no_queue: flush=%b busy=%b, want 0 0", flush_o, busy_o);
        end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        logic [3:0] want = 4'b1000;
        do_reset();
        stallreq_id = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (timeout_o !== want[i]) begin
                tests_failed++;
                $display("FAIL wd_trip[%0d]: timeout=%b, want %b", i, timeout_o, want[i]);
            end
        end
        stallreq_id = 0;
        step();
        step();
        tests_run++;
        if (timeout_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_sticky: timeout=%b, want 1", timeout_o);
        end
        do_reset();
        for (int i = 0; i < 7; i++) begin
            stallreq_id = (i != 3);
            step();
        end
        stallreq_id = 0;
        step();
        tests_run++;
        if (timeout_o !== 1'b0 || stall_cnt_o !== 32'd6) begin
            tests_failed++;
            $display("FAIL wd_gap: timeout=%b stall_cnt=%0d, want 0 6", timeout_o, stall_cnt_o);
        end
    endtask

    task automatic test_flush_over_stall_and_rst();
        do_reset();
        exc_i = 1;
        step();
        exc_i = 0;
        stallreq_mem = 1;
        #1;
        tests_run++;
        if (flush_o !== 1'b1 || stall_o !== 6'b0) begin
            tests_failed++;
            $display("FAIL flush_over_stall: flush=%b stall=%b, want 1 000000", flush_o, stall_o);
        end
        step();
        tests_run++;
        if (stall_o !== 6'b011111 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL refill_stall: stall=%b busy=%b, want 011111 1", stall_o, busy_o);
        end
        rst = 1;
        step();
        rst = 0;
        stallreq_mem = 0;
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || flush_o !== 1'b0 || stall_cnt_o !== 32'd0 || new_pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_in_refill: busy=%b flush=%b stall_cnt=%0d new_pc=%h, want 0 0 0 0",
                     busy_o, flush_o, stall_cnt_o, new_pc_o);
        end
    endtask

    task automatic test_back_to_back_refill0();
        do_reset();
        exc_i = 1;
        step();
        exc_i = 0;
        tests_run++;
        if (flush0_o !== 1'b1 || new_pc0_o !== 32'h00000020) begin
            tests_failed++;
            $display("FAIL rc0_flush: flush=%b new_pc=%h, want 1 00000020", flush0_o, new_pc0_o);
        end
        eret_i = 1;
        epc_i = 32'h00000ABC;
        step();
        tests_run++;
        if (flush0_o !== 1'b0 || busy0_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rc0_idle: flush=%b busy=%b, want 0 0", flush0_o, busy0_o);
        end
        step();
        clear_inputs();
        tests_run++;
        if (flush0_o !== 1'b1 || new_pc0_o !== 32'h00000ABC) begin
            tests_failed++;
            $display("FAIL rc0_second: flush=%b new_pc=%h, want 1 00000abc", flush0_o, new_pc0_o);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_ex_stall();
        test_exc_flush();
        test_eret_mem_stall();
        test_exc_in_refill();
        test_watchdog();
        test_flush_over_stall_and_rst();
        test_back_to_back_refill0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 6-entry stall bus stall[5:0]: bit 0 = PC, bit 1 = IF/ID, bit 2 = ID/EX, bit 3 = EX/MEM, bit 4 = MEM/WB, bit 5 = WB.
- Turns per-stage stall requests into the stall vector, so that downstream pipeline registers insert bubbles where stall[k]=1 and stall[k+1]=0.
- Runs the exception/ERET redirect sequence: one-cycle flush, new PC, refill guard window.
- Provides a stall watchdog and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 1024: consecutive stalled cycles that trip timeout_o; 1..65535.
- EXC_VECTOR, 32'h00000020: redirect PC for exceptions.
- REFILL_CYCLES, 2: cycles after a flush during which new exception/ERET requests are ignored; 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallreq_if  in  1  IF stage requests a stall.
- stallreq_id  in  1  ID stage requests a stall.
- stallreq_ex  in  1  EX stage requests a stall (multi-cycle op).
- stallreq_mem  in  1  MEM stage requests a stall (bus wait).
- exc_i  in  1  MEM stage reports an exception.
- eret_i  in  1  MEM stage reports ERET.
- epc_i  in  32  return address for ERET.
- stall_o  out  6  stall vector to all pipeline registers.
- flush_o  out  1  flush all pipeline registers.
- new_pc_o  out  32  redirect target, valid while flush_o=1.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  32  stalled-cycle count.

Behaviour:
- FSM states: IDLE, FLUSH, REFILL.
- Reset (clk edge with rst=1) sets: state=IDLE; new_pc_o=0; refill counter=0; watchdog counter=0; timeout_o=0; stall_cnt_o=0. Consequently flush_o=0, busy_o=0, stall_o=0 (given no requests).
- stall_o is combinational, same cycle as the requests. The highest requesting stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- stall_o[5] is never 1.
- In FLUSH, stall_o=0 regardless of requests; flush overrides stall.
- IDLE -> FLUSH at a clock edge when (exc_i | eret_i) = 1 and stallreq_mem = 0. The same edge latches new_pc_o:
  - EXC_VECTOR if exc_i=1 (exc_i has priority when both are high);
  - otherwise epc_i.
- If stallreq_mem=1, exc_i/eret_i are not accepted that cycle; the MEM stage holds them.
- FLUSH lasts exactly 1 cycle with flush_o=1. Next state:
  - REFILL with counter = REFILL_CYCLES-1, if REFILL_CYCLES>0;
  - otherwise IDLE.
- REFILL: stall_o is normal and flush_o=0. exc_i/eret_i are ignored (not queued). Counter decrements each cycle; when it is 0, go to IDLE.
- With REFILL_CYCLES=0, FLUSH goes directly to IDLE, and a new request can be taken on the very next edge.
- new_pc_o holds its last latched value outside FLUSH.
- flush_o is a registered state decode: exactly one cycle per accepted event, asserted in the cycle after the accept edge.
- Watchdog:
  - 16-bit counter increments each cycle stall_o != 0, saturating at TIMEOUT.
  - Cleared to 0 in any cycle with stall_o == 0.
  - When it reaches TIMEOUT, timeout_o is set at that edge and stays set until rst.
- stall_cnt_o increments each cycle stall_o != 0 and saturates at 32'hFFFFFFFF.
- rst asserted mid-sequence (FLUSH or REFILL) returns to IDLE at that edge; counters and timeout_o are cleared.

Test Plan:
- Reset, then stallreq_ex=1 and stallreq_if=1 for 3 cycles -> stall_o=6'b001111 in those cycles; stall_cnt_o=3 after; timeout_o=0.
- exc_i=1 and eret_i=1 (epc_i=32'h00001000) for one cycle, no stalls -> next cycle flush_o=1, new_pc_o=32'h00000020, stall_o=0; busy_o stays 1 for 3 cycles total (REFILL_CYCLES=2); flush_o is high exactly once.
- eret_i=1 with epc_i=32'h00400100 while stallreq_mem=1 for 2 cycles, then stallreq_mem=0 -> no flush while stalled; flush_o=1 with new_pc_o=32'h00400100 one cycle after release.
- exc_i pulse during REFILL -> ignored: no second flush_o; state returns to IDLE on schedule.
- TIMEOUT=4, stallreq_id held 4 cycles -> timeout_o=1 after the 4th edge and stays 1 when requests drop. A 3-cycle stall, then a 1-cycle gap, then a 3-cycle stall never sets timeout_o.
- FLUSH during stallreq_mem=1 (request arriving in the flush cycle) -> stall_o=0 in FLUSH, 6'b011111 the next cycle. rst asserted in REFILL -> IDLE, busy_o=0, stall_cnt_o=0.
